// File: rtl/rv32_pkg.sv
// Shared RV32 integer-datapath constants used by the writeback and decode stages.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_select.sv
// Writeback value select: load data or ALU result. Shared with the forwarding network.
module wb_select #(
  parameter int XLEN = 32
) (
  input  logic            mem_to_reg,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] wb_data
);

  assign wb_data = mem_to_reg ? mem_data : alu_result;

endmodule

// File: rtl/wb_regfile.sv
// Writeback commit into the 32x32 integer register file, two bypassed decode read
// ports, a one-cycle-delayed commit trace and a retired-write counter.
module wb_regfile #(
  parameter int XLEN  = rv32_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [XLEN-1:0]               mem_data_WB_in,
  input  logic [XLEN-1:0]               alu_WB_in,
  input  logic                          RegWrite_WB_in,
  input  logic                          MemtoReg_WB_in,
  input  logic [rv32_pkg::REG_ADDR_W-1:0] rd_WB_in,
  input  logic [rv32_pkg::REG_ADDR_W-1:0] rs1_ID_in,
  input  logic [rv32_pkg::REG_ADDR_W-1:0] rs2_ID_in,
  output logic [XLEN-1:0]               rs1_data_ID_out,
  output logic [XLEN-1:0]               rs2_data_ID_out,
  output logic                          commit_valid_out,
  output logic [rv32_pkg::REG_ADDR_W-1:0] commit_rd_out,
  output logic [XLEN-1:0]               commit_data_out,
  output logic [CNT_W-1:0]              retired_cnt_out
);

  import rv32_pkg::*;

  logic [XLEN-1:0]  wb_data;
  logic             we_eff;
  // x0 is never stored; its reads are forced to zero below.
  logic [XLEN-1:0]  regs [1:NUM_REGS-1];

  wb_select #(.XLEN(XLEN)) u_wb_select (
    .mem_to_reg (MemtoReg_WB_in),
    .mem_data   (mem_data_WB_in),
    .alu_result (alu_WB_in),
    .wb_data    (wb_data)
  );

  assign we_eff = RegWrite_WB_in && (rd_WB_in != REG_ZERO);

  // Same-cycle write-through keeps the WB->ID hazard stall-free.
  always_comb begin
    rs1_data_ID_out = '0;
    if (rs1_ID_in == REG_ZERO) begin
      rs1_data_ID_out = '0;
    end else if (we_eff && (rs1_ID_in == rd_WB_in)) begin
      rs1_data_ID_out = wb_data;
    end else begin
      rs1_data_ID_out = regs[rs1_ID_in];
    end
  end

  always_comb begin
    rs2_data_ID_out = '0;
    if (rs2_ID_in == REG_ZERO) begin
      rs2_data_ID_out = '0;
    end else if (we_eff && (rs2_ID_in == rd_WB_in)) begin
      rs2_data_ID_out = wb_data;
    end else begin
      rs2_data_ID_out = regs[rs2_ID_in];
    end
  end

  // Reset wins over a concurrent write: nothing is stored or counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we_eff) begin
      regs[rd_WB_in] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_valid_out <= 1'b0;
      commit_rd_out    <= '0;
      commit_data_out  <= '0;
      retired_cnt_out  <= '0;
    end else begin
      commit_valid_out <= we_eff;
      commit_rd_out    <= rd_WB_in;
      commit_data_out  <= wb_data;
      if (we_eff) begin
        retired_cnt_out <= retired_cnt_out + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side consumer of the MEM/WB pipeline register, and the ID-stage source of register operands. It selects the writeback value (memory data or ALU result), commits it to a 32×32 integer register file, and serves two combinational read ports to decode with same-cycle write-through bypass. It also provides a registered commit trace and a retired-write counter for the debug and verification infrastructure.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, width of retired-write counter

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- mem_data_WB_in  input  XLEN  load data from MEM/WB
- alu_WB_in  input  XLEN  ALU result from MEM/WB
- RegWrite_WB_in  input  1  write enable from MEM/WB
- MemtoReg_WB_in  input  1  1 = write load data, 0 = write ALU result
- rd_WB_in  input  5  destination register
- rs1_ID_in  input  5  read address, port 1
- rs2_ID_in  input  5  read address, port 2
- rs1_data_ID_out  output  XLEN  operand 1 (combinational)
- rs2_data_ID_out  output  XLEN  operand 2 (combinational)
- commit_valid_out  output  1  registered: a write committed last cycle
- commit_rd_out  output  5  registered: rd of that write
- commit_data_out  output  XLEN  registered: data of that write
- retired_cnt_out  output  CNT_W  count of committed writes

## Operation
- wb_data = MemtoReg_WB_in ? mem_data_WB_in : alu_WB_in.
- we_eff = RegWrite_WB_in && (rd_WB_in != 0).
- On a rising edge with rst_n = 1 and we_eff = 1, regs[rd_WB_in] is set to wb_data.
- x0 is hardwired to 0. Writes to x0 are dropped and do not count as commits. A read of x0 always returns 0, including under bypass.
- Read port k returns wb_data when we_eff and rs_k == rd_WB_in (write-through bypass). Otherwise it returns regs[rs_k]. The two ports are independent, and both may bypass in the same cycle.
- Commit trace: each edge registers commit_valid_out ← we_eff, commit_rd_out ← rd_WB_in, commit_data_out ← wb_data. When we_eff = 0, rd and data still update, and consumers must qualify them with valid.
- retired_cnt_out increments by 1 per edge with we_eff = 1. It wraps from 2^CNT_W−1 to 0 without saturation or flag.
- Reset (rst_n = 0 at an edge):
  - all 31 registers are cleared to 0;
  - commit_valid_out = 0, commit_rd_out = 0, commit_data_out = 0, retired_cnt_out = 0.
  - Reset has priority over a concurrent write: the write is lost and not counted.
  - While rst_n = 0, reads still bypass on we_eff. Decode is flushed during reset, so this is harmless.

## Timing
- Write latency is 1 edge. A read of rd in the following cycle without bypass sees the new value.
- Bypass is 0-cycle: a read issued in the same cycle as the write returns the new data. This removes the WB→ID hazard with no stall.
- Commit trace and counter lag the writeback inputs by exactly 1 cycle.
- The only combinational paths are from WB inputs and rs addresses to the read data. There is no path from reads into state.
- Reset is synchronous only; asserting rst_n between edges has no effect until the next edge.

## Structure
- The shared package rv32_pkg holds:
  - XLEN = 32, REG_ADDR_W = 5, NUM_REGS = 32;
  - the x0 constant (REG_ZERO = 5'd0).
- Sub-module wb_select: the combinational MemtoReg mux producing wb_data. It is reused by forwarding logic elsewhere.
- Storage is a flat register array of entries 1..31. Entry 0 is not stored.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles, then read all 32 addresses → all 0; commit_valid_out = 0; retired_cnt_out = 0.
- ALU write then read: rd = 5, alu = 0xDEADBEEF, MemtoReg = 0, RegWrite = 1.
  - Same cycle, rs1 = 5 → 0xDEADBEEF via bypass.
  - Next cycle, with RegWrite = 0 → 0xDEADBEEF from storage.
  - commit_rd_out = 5, commit_valid_out = 1, retired_cnt_out = 1.
- Load select and dual bypass: rd = 7, mem_data = 0x12345678, alu = 0xFFFFFFFF, MemtoReg = 1, rs1 = rs2 = 7 → both ports read 0x12345678.
- x0 write: rd = 0, RegWrite = 1, alu = 0xAAAA5555, rs1 = 0 → reads 0 in the same and next cycle; commit_valid_out = 0; counter unchanged.
- Reset collides with write: rst_n = 0 on the same edge as a write of rd = 3 with 0x11 → x3 reads 0 afterwards; counter = 0.
- Counter wrap: with CNT_W = 4, perform 17 writes → retired_cnt_out = 1.
